// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_unit
// Purpose  : Load-use stall, branch flush and MUL/DIV sequencing for the
//            5-stage core, with a saturating stall-cycle counter.
// Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl_unit #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic [4:0]       rd_ex,
    input  logic             mem_read_ex,
    input  logic             branch_taken_ex,
    input  logic             md_op_ex,
    input  logic             md_done,
    output logic             md_go,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             bubble_ex,
    output logic             bubble_mem,
    output logic             flush_if_id,
    output logic             md_busy,
    output logic             md_error,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [0:0] c_RUN     = 1'b0;
    localparam logic [0:0] c_MD_WAIT = 1'b1;

    localparam int                    c_WCNT_W    = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [c_WCNT_W-1:0]   c_WAIT_LAST = c_WCNT_W'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]      c_CNT_MAX   = {CNT_W{1'b1}};

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [c_WCNT_W-1:0] r_wait_cnt;
    logic [c_WCNT_W-1:0] w_wait_nxt;
    logic                r_md_error;
    logic                w_set_error;
    logic [CNT_W-1:0]    r_stall_count;
    logic                w_load_use;

    assign w_load_use = mem_read_ex && (rd_ex != 5'd0) &&
                        ((rd_ex == rs1_id) || (rd_ex == rs2_id));

    always_comb begin
        md_go       = 1'b0;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        bubble_ex   = 1'b0;
        bubble_mem  = 1'b0;
        flush_if_id = 1'b0;
        md_busy     = 1'b0;
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_set_error = 1'b0;
        case (r_state)
            c_RUN: begin
                if (md_op_ex) begin
                    md_go       = 1'b1;
                    stall_if    = 1'b1;
                    stall_id    = 1'b1;
                    stall_ex    = 1'b1;
                    bubble_mem  = 1'b1;
                    w_state_nxt = c_MD_WAIT;
                    w_wait_nxt  = '0;
                end else if (branch_taken_ex) begin
                    // The ID instruction is flushed, so its load-use hazard is moot.
                    flush_if_id = 1'b1;
                    bubble_ex   = 1'b1;
                end else if (w_load_use) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
            end
            c_MD_WAIT: begin
                md_busy = 1'b1;
                if (md_done) begin
                    // Release everything so the MUL/DIV result advances to MEM.
                    w_state_nxt = c_RUN;
                end else begin
                    stall_if   = 1'b1;
                    stall_id   = 1'b1;
                    stall_ex   = 1'b1;
                    bubble_mem = 1'b1;
                    if (r_wait_cnt == c_WAIT_LAST) begin
                        w_state_nxt = c_RUN;
                        w_set_error = 1'b1;
                    end else begin
                        w_wait_nxt = r_wait_cnt + c_WCNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = c_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_RUN;
            r_wait_cnt    <= '0;
            r_md_error    <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_set_error)
                r_md_error <= 1'b1;
            if (stall_if && (r_stall_count != c_CNT_MAX))
                r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign md_error    = r_md_error;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl_unit
// Purpose  : Scoreboard bench for hazard_ctrl_unit: directed scenarios then
//            random traffic against a cycle-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl_unit;

    localparam int MD_TIMEOUT = 8;
    localparam int CNT_W      = 4;

    typedef struct packed {
        logic [8:0]       ctl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       rs1_id = '0, rs2_id = '0, rd_ex = '0;
    logic             mem_read_ex = 1'b0, branch_taken_ex = 1'b0;
    logic             md_op_ex = 1'b0, md_done = 1'b0;
    logic             md_go, stall_if, stall_id, stall_ex, bubble_ex, bubble_mem;
    logic             flush_if_id, md_busy, md_error;
    logic [CNT_W-1:0] stall_count;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    // Reference model state: -1 means running, otherwise cycles already waited.
    int m_wait = -1;
    bit m_err  = 1'b0;
    int m_cnt  = 0;

    hazard_ctrl_unit #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
        .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex),
        .md_op_ex(md_op_ex), .md_done(md_done),
        .md_go(md_go), .stall_if(stall_if), .stall_id(stall_id),
        .stall_ex(stall_ex), .bubble_ex(bubble_ex), .bubble_mem(bubble_mem),
        .flush_if_id(flush_if_id), .md_busy(md_busy), .md_error(md_error),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit go, sif, sid, sex, bex, bmem, fl, busy;
        bit lu;
        exp_t e;
        go = 0; sif = 0; sid = 0; sex = 0; bex = 0; bmem = 0; fl = 0; busy = 0;
        if (rst) begin
            m_wait = -1; m_err = 0; m_cnt = 0;
        end
        lu = mem_read_ex && rd_ex != 0 && (rd_ex == rs1_id || rd_ex == rs2_id);
        if (m_wait < 0) begin
            if (md_op_ex) begin
                go = 1; sif = 1; sid = 1; sex = 1; bmem = 1;
            end else if (branch_taken_ex) begin
                fl = 1; bex = 1;
            end else if (lu) begin
                sif = 1; sid = 1; bex = 1;
            end
        end else begin
            busy = 1;
            if (!md_done) begin
                sif = 1; sid = 1; sex = 1; bmem = 1;
            end
        end
        e.ctl = {go, sif, sid, sex, bex, bmem, fl, busy, m_err};
        e.cnt = CNT_W'(m_cnt);
        q.push_back(e);
        if (!rst) begin
            if (sif && m_cnt < (1 << CNT_W) - 1)
                m_cnt = m_cnt + 1;
            if (m_wait < 0) begin
                if (md_op_ex) m_wait = 0;
            end else if (md_done) begin
                m_wait = -1;
            end else if (m_wait == MD_TIMEOUT - 1) begin
                m_wait = -1;
                m_err  = 1;
            end else begin
                m_wait = m_wait + 1;
            end
        end
    endtask

    task automatic drive(input bit r, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input bit mr, input bit br,
                         input bit op, input bit dn);
        @(posedge clk);
        #1;
        rst = r; rs1_id = a; rs2_id = b; rd_ex = d;
        mem_read_ex = mr; branch_taken_ex = br; md_op_ex = op; md_done = dn;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are valid every cycle, compared mid-cycle.
    initial begin
        exp_t e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {md_go, stall_if, stall_id, stall_ex, bubble_ex, bubble_mem,
                       flush_if_id, md_busy, md_error};
                n_checks++;
                if (act !== e.ctl) begin
                    n_fails++;
                    $display("FAIL ctl at %0t: got %b expected %b (go,sif,sid,sex,bex,bmem,flush,busy,err)",
                             $time, act, e.ctl);
                end
                n_checks++;
                if (stall_count !== e.cnt) begin
                    n_fails++;
                    $display("FAIL stall_count at %0t: got %0d expected %0d", $time, stall_count, e.cnt);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // Load-use on rs2, then rd_ex = x0 which never hazards.
        drive(0, 0, 5, 5, 1, 0, 0, 0);
        idle(1);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        idle(1);
        // Branch overrides load-use.
        drive(0, 3, 0, 3, 1, 1, 0, 0);
        idle(1);
        // MUL/DIV with done on the fourth wait cycle.
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        // Timeout, then a stray done.
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        idle(MD_TIMEOUT + 2);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        // Reset mid-wait, then a fresh handshake.
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        // Saturation of the stall counter.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(0, 7, 0, 7, 1, 0, 0, 0);
            idle(1);
        end
        // Random traffic.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0)
                drive(1, 0, 0, 0, 0, 0, 0, 0);
            else
                drive(0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                      $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 4) == 0);
        end
        idle(1);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fails++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Pipeline hazard and sequencing controller for the 5-stage integer core. It sits beside the operand-forwarding logic and covers the cases forwarding cannot resolve. It stalls IF/ID for load-use hazards, flushes younger stages on taken branches, and sequences the multi-cycle MUL/DIV unit with a start/done handshake and a watchdog. It also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
MD_TIMEOUT, 64, max cycles spent in MD_WAIT before abort (must be >=2)
CNT_W, 16, width of stall_count

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous active-high reset
rs1_id  input  5  source reg 1 of instruction in ID
rs2_id  input  5  source reg 2 of instruction in ID
rd_ex  input  5  destination reg of instruction in EX
mem_read_ex  input  1  EX instruction is a load
branch_taken_ex  input  1  EX resolved a taken branch/jump
md_op_ex  input  1  EX instruction is a MUL/DIV op
md_done  input  1  MUL/DIV unit result valid (one-cycle pulse)
md_go  output  1  one-cycle start pulse to MUL/DIV unit
stall_if  output  1  hold PC
stall_id  output  1  hold IF/ID register
stall_ex  output  1  hold ID/EX register
bubble_ex  output  1  load NOP into ID/EX
bubble_mem  output  1  load NOP into EX/MEM
flush_if_id  output  1  clear IF/ID to NOP
md_busy  output  1  FSM in MD_WAIT
md_error  output  1  sticky: MUL/DIV timeout occurred
stall_count  output  CNT_W  cycles with stall_if=1, saturating

Behaviour:
- Reset (async, rst=1): state=RUN, wait_cnt=0, md_error=0, stall_count=0. All stall/bubble/flush/md_go outputs=0 during and after reset until a hazard is present.
- Control outputs are combinational from the current state and inputs. The state, wait_cnt, md_error and stall_count are registered.
- load_use = mem_read_ex & (rd_ex!=0) & ((rd_ex==rs1_id)|(rd_ex==rs2_id)).
- State RUN, evaluated in priority order:
  1. md_op_ex=1: md_go=1, stall_if=stall_id=stall_ex=1, bubble_mem=1. Next state=MD_WAIT, wait_cnt<=0. branch_taken_ex and load_use are ignored in this cycle.
  2. branch_taken_ex=1: flush_if_id=1, bubble_ex=1, no stall. load_use is ignored because the ID instruction is being flushed.
  3. load_use=1: stall_if=stall_id=1, bubble_ex=1. Exactly one stall cycle; the hazard clears as the load moves to MEM.
  4. Otherwise all outputs are 0.
  - md_done in RUN is ignored.
- State MD_WAIT: md_busy=1. branch_taken_ex, load_use and md_op_ex are ignored.
  - md_done=0 and wait_cnt<MD_TIMEOUT-1: stall_if=stall_id=stall_ex=1, bubble_mem=1, wait_cnt++.
  - md_done=1: all stalls and bubbles are 0 this cycle so the MD result advances to MEM. Next state=RUN.
  - md_done=0 and wait_cnt==MD_TIMEOUT-1: stalls are still asserted this cycle. Next state=RUN, md_error<=1 (sticky until rst).
  - md_go=0 in all MD_WAIT cycles; there is no reissue.
- md_done coincident with md_go (RUN) is ignored. The MUL/DIV unit's minimum latency is 1 cycle after md_go.
- stall_count increments on every cycle with stall_if=1 and holds at 2^CNT_W-1.
- rst asserted mid-MD_WAIT: FSM goes to RUN immediately and md_go is not re-pulsed. The pipeline and MUL/DIV unit reset together.
- md_busy=1 iff state==MD_WAIT. md_go=1 only in RUN with md_op_ex=1, so it is never high two consecutive cycles unless the second cycle follows a done/timeout.

Test Plan:
- Load-use: mem_read_ex=1, rd_ex=5, rs2_id=5 for one cycle -> stall_if=stall_id=bubble_ex=1 that cycle only; stall_count=1. Repeat with rd_ex=0 -> no stall.
- Branch vs load-use: branch_taken_ex=1, mem_read_ex=1, rd_ex=3, rs1_id=3 -> flush_if_id=1, bubble_ex=1, stall_if=0; stall_count unchanged.
- MUL/DIV handshake: md_op_ex=1 at cycle 0, md_done at cycle 4 -> md_go=1 at cycle 0 only; stall_if=stall_ex=bubble_mem=1 at cycles 0-3; all 0 at cycle 4; md_busy=1 at cycles 1-4; RUN at cycle 5; stall_count=4.
- Timeout: MD_TIMEOUT=8, md_op_ex=1, md_done never asserted -> stalls held for 9 cycles (issue + 8 wait); md_error=1 from the following cycle onward; state RUN. A later md_done pulse has no effect.
- Reset mid-wait: rst pulsed at MD_WAIT cycle 2 -> all outputs 0 asynchronously; md_busy=0, stall_count=0, md_error=0. A subsequent md_op_ex starts a fresh handshake with md_go=1.
- Saturation: CNT_W=4, hold load_use on 20 distinct cycles -> stall_count stops at 15.
